// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e   : controller state (NORMAL, STALL)
//   WBSRC_DM  : write-back source code meaning "data memory" (a load)
//   FWD_*     : operand forwarding select encodings for EX
package hazard_pkg;
    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } state_e;

    localparam logic [1:0] WBSRC_DM = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ME = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;
endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the EX stage.
//   i_rs      : source register read by the EX instruction
//   i_rd_me   : ME destination,  i_ruwr_me : ME writes the register file
//   i_rd_wb   : WB destination,  i_ruwr_wb : WB writes the register file
//   o_sel     : FWD_RF / FWD_ME / FWD_WB
// The younger producer (ME) wins over WB; x0 is hard-wired zero and never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rd_me,
    input  logic       i_ruwr_me,
    input  logic [4:0] i_rd_wb,
    input  logic       i_ruwr_wb,
    output logic [1:0] o_sel
);
    always_comb begin
        o_sel = FWD_RF;
        if (i_rs != 5'd0) begin
            if (i_ruwr_me && (i_rd_me == i_rs))
                o_sel = FWD_ME;
            else if (i_ruwr_wb && (i_rd_wb == i_rs))
                o_sel = FWD_WB;
        end
    end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flush, EX operand
// forwarding selects and a saturating stall-cycle counter.
// Configuration macro: FWD_EN
//   defined   : EX forwarding selects are active
//   undefined : selects tied to FWD_RF; any RAW hazard between decode sources
//               and a writing EX/ME/WB destination stalls decode for the cycle
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rs1_de, rs2_de        : decode sources
//   rs1_ex, rs2_ex        : execute sources
//   RD_*/RUWr_*           : destination / write-enable of EX, ME, WB
//   RUDataWrSrc_ex        : EX write-back source (WBSRC_DM = load)
//   BrTaken_ex            : branch resolved taken in EX
//   Stall_fe, Stall_de    : hold PC and IF/ID
//   Clr_fd                : flush IF/ID
//   Clr1, Clr2            : ID/EX bubble (load-use) / flush (branch)
//   FwdA_ex, FwdB_ex      : EX operand selects
//   stall_count           : cycles with Stall_fe=1, saturating
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_W            = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rs1_de,
    input  logic [4:0]        rs2_de,
    input  logic [4:0]        rs1_ex,
    input  logic [4:0]        rs2_ex,
    input  logic [4:0]        RD_ex,
    input  logic              RUWr_ex,
    input  logic [1:0]        RUDataWrSrc_ex,
    input  logic [4:0]        RD_me,
    input  logic              RUWr_me,
    input  logic [4:0]        RD_wb,
    input  logic              RUWr_wb,
    input  logic              BrTaken_ex,
    output logic              Stall_fe,
    output logic              Stall_de,
    output logic              Clr_fd,
    output logic              Clr1,
    output logic              Clr2,
    output logic [1:0]        FwdA_ex,
    output logic [1:0]        FwdB_ex,
    output logic [PERF_W-1:0] stall_count
);
`ifdef FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // The first bubble is issued from NORMAL, so the counter covers the rest.
    localparam logic [3:0] CNT_INIT =
        (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_e            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [PERF_W-1:0] r_stall_count;
    logic              w_lu, w_raw, w_stall, w_flush;
    logic [1:0]        w_fwd_a, w_fwd_b;

    assign w_lu = RUWr_ex && (RUDataWrSrc_ex == WBSRC_DM) && (RD_ex != 5'd0) &&
                  ((RD_ex == rs1_de) || (RD_ex == rs2_de));

    // Only consulted without forwarding: any in-flight producer of a decode source.
    assign w_raw = !FWD_ON && (
        (RUWr_ex && (RD_ex != 5'd0) && ((RD_ex == rs1_de) || (RD_ex == rs2_de))) ||
        (RUWr_me && (RD_me != 5'd0) && ((RD_me == rs1_de) || (RD_me == rs2_de))) ||
        (RUWr_wb && (RD_wb != 5'd0) && ((RD_wb == rs1_de) || (RD_wb == rs2_de))));

    hazard_fwd_sel u_fwd_a (
        .i_rs(rs1_ex), .i_rd_me(RD_me), .i_ruwr_me(RUWr_me),
        .i_rd_wb(RD_wb), .i_ruwr_wb(RUWr_wb), .o_sel(w_fwd_a)
    );
    hazard_fwd_sel u_fwd_b (
        .i_rs(rs2_ex), .i_rd_me(RD_me), .i_ruwr_me(RUWr_me),
        .i_rd_wb(RD_wb), .i_ruwr_wb(RUWr_wb), .o_sel(w_fwd_b)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_flush     = 1'b0;
        if (!rst) begin
            case (r_state)
                NORMAL: begin
                    // Decode holds a wrong-path instruction when a branch is taken.
                    if (BrTaken_ex) begin
                        w_flush = 1'b1;
                    end else if (w_lu) begin
                        w_stall = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            w_state_nxt = STALL;
                            w_cnt_nxt   = CNT_INIT;
                        end
                    end else if (w_raw) begin
                        w_stall = 1'b1;
                    end
                end
                STALL: begin
                    if (BrTaken_ex) begin
                        w_flush     = 1'b1;
                        w_state_nxt = NORMAL;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_stall = 1'b1;
                        if (r_cnt == 4'd0)
                            w_state_nxt = NORMAL;
                        else
                            w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                default: w_state_nxt = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= NORMAL;
            r_cnt         <= 4'd0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + PERF_W'(1);
        end
    end

    always_comb begin
        Stall_fe    = w_stall;
        Stall_de    = w_stall;
        Clr1        = w_stall;
        Clr_fd      = w_flush;
        Clr2        = w_flush;
        FwdA_ex     = (rst || !FWD_ON) ? FWD_RF : w_fwd_a;
        FwdB_ex     = (rst || !FWD_ON) ? FWD_RF : w_fwd_b;
        stall_count = r_stall_count;
    end
endmodule
